// File: rtl/ssd_scan_controller.sv
// Probe display sequencer: picks a probe source (auto-scan or manual), converts its value to BCD
// with a shift-add-3 engine and drives a 4-digit multiplexed seven-segment display.
module ssd_scan_controller #(
    parameter int NUM_W      = 14,
    parameter int NUM_SRC    = 12,
    parameter int DWELL_CYC  = 100000000,
    parameter int SAMPLE_CYC = 1000000,
    parameter int REFRESH_W  = 20,
    parameter int BLANK_LZ   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             auto_en,
    input  logic [3:0]       man_sel,
    input  logic [NUM_W-1:0] value_in,
    output logic [3:0]       sel_out,
    output logic             busy,
    output logic [3:0]       Anode,
    output logic [6:0]       LED_out
);
    localparam int DW   = $clog2(DWELL_CYC);
    localparam int SW   = $clog2(SAMPLE_CYC);
    localparam int BW   = $clog2(NUM_W + 1);
    localparam int SR_W = NUM_W + 16;
    localparam logic [3:0] DASH = 4'hA;

    typedef enum logic [1:0] {IDLE, LOAD, CONV, UPDATE} state_t;

    state_t              state, state_next;
    logic                load_en, conv_en, upd_en;
    logic [3:0]          sel_prev;
    logic [DW-1:0]       dwell_cnt;
    logic [SW-1:0]       samp_cnt;
    logic                samp_exp, man_ok, trigger, pending;
    logic [SR_W-1:0]     sr, sr_adj;
    logic [BW-1:0]       bit_cnt;
    logic                ovf;
    logic [15:0]         disp;
    logic [REFRESH_W-1:0] ref_cnt;
    logic [1:0]          idx;
    logic [3:0]          cur_digit, anode_next;
    logic                blank;
    logic [6:0]          seg;

    assign samp_exp = (samp_cnt == SW'(SAMPLE_CYC - 1));
    assign man_ok   = ({28'd0, man_sel} < 32'(NUM_SRC));
    assign trigger  = (sel_out != sel_prev) || samp_exp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_out   <= 4'd0;
            sel_prev  <= 4'd0;
            dwell_cnt <= '0;
            samp_cnt  <= '0;
        end else begin
            sel_prev <= sel_out;
            samp_cnt <= samp_exp ? '0 : samp_cnt + SW'(1);
            if (auto_en) begin
                if (dwell_cnt == DW'(DWELL_CYC - 1)) begin
                    dwell_cnt <= '0;
                    sel_out   <= (sel_out == 4'(NUM_SRC - 1)) ? 4'd0 : sel_out + 4'd1;
                end else begin
                    dwell_cnt <= dwell_cnt + DW'(1);
                end
            end else begin
                dwell_cnt <= '0;
                sel_out   <= man_ok ? man_sel : 4'd0;
            end
        end
    end

    always_comb begin
        state_next = state;
        load_en    = 1'b0;
        conv_en    = 1'b0;
        upd_en     = 1'b0;
        case (state)
            IDLE:   if (trigger || pending) state_next = LOAD;
            LOAD:   begin load_en = 1'b1; state_next = CONV; end
            CONV:   begin conv_en = 1'b1; if (bit_cnt == BW'(1)) state_next = UPDATE; end
            UPDATE: begin upd_en = 1'b1; state_next = IDLE; end
            default: state_next = IDLE;
        endcase
    end

    // A trigger arriving mid-conversion is remembered once and served after UPDATE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= LOAD;
            pending <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE)  pending <= 1'b0;
            else if (trigger)   pending <= 1'b1;
            if (state_next == LOAD || load_en) busy <= 1'b1;
            else if (upd_en)                   busy <= 1'b0;
        end
    end

    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 4; i++) begin
            if (sr[NUM_W + 4*i +: 4] >= 4'd5)
                sr_adj[NUM_W + 4*i +: 4] = sr[NUM_W + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr      <= '0;
            bit_cnt <= '0;
            ovf     <= 1'b0;
            disp    <= '0;
        end else begin
            if (load_en) begin
                sr      <= {16'd0, value_in};
                bit_cnt <= BW'(NUM_W);
                ovf     <= (32'(value_in) > 32'd9999);
            end else if (conv_en) begin
                sr      <= {sr_adj[SR_W-2:0], 1'b0};
                bit_cnt <= bit_cnt - BW'(1);
            end
            if (upd_en) disp <= ovf ? {4{DASH}} : sr[SR_W-1 -: 16];
        end
    end

    assign idx = ref_cnt[REFRESH_W-1 -: 2];

    always_comb begin
        cur_digit  = disp[3:0];
        anode_next = 4'b1110;
        blank      = 1'b0;
        case (idx)
            2'd0: begin cur_digit = disp[15:12]; anode_next = 4'b0111; blank = (disp[15:12] == 4'd0); end
            2'd1: begin cur_digit = disp[11:8];  anode_next = 4'b1011; blank = (disp[15:8] == 8'd0);  end
            2'd2: begin cur_digit = disp[7:4];   anode_next = 4'b1101; blank = (disp[15:4] == 12'd0); end
            default: begin cur_digit = disp[3:0]; anode_next = 4'b1110; blank = 1'b0; end
        endcase
        if (BLANK_LZ == 0) blank = 1'b0;
    end

    always_comb begin
        case (cur_digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            DASH:    seg = 7'b1111110;
            default: seg = 7'b1111111;
        endcase
    end

    // Outputs lag the refresh index by one cycle; they only ever see committed digits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_cnt <= '0;
            Anode   <= 4'b1111;
            LED_out <= 7'b1111111;
        end else begin
            ref_cnt <= ref_cnt + REFRESH_W'(1);
            Anode   <= anode_next;
            LED_out <= blank ? 7'b1111111 : seg;
        end
    end
endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller: a plain-display and a leading-zero-blanking instance share
// stimulus; vectors are table-driven, mode/pending/reset corners are hand-written sequences.
module tb_ssd_scan_controller;
    localparam int NUM_W = 14;
    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110,
                           S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111,
                           S8 = 7'b0000000, S9 = 7'b0000100, SD = 7'b1111110, SB = 7'b1111111;

    typedef struct {
        logic [13:0] value;
        logic [27:0] exp_a;
        logic [27:0] exp_b;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, auto_en;
    logic [3:0]       man_sel;
    logic [13:0]      src_val [16];
    logic [13:0]      value_a, value_b;
    logic [3:0]       sel_a, sel_b, anode_a, anode_b;
    logic             busy_a, busy_b;
    logic [6:0]       led_a, led_b;

    int n_cmp = 0;
    int n_err = 0;

    assign value_a = src_val[sel_a];
    assign value_b = src_val[sel_b];

    ssd_scan_controller #(.NUM_W(NUM_W), .NUM_SRC(12), .DWELL_CYC(40), .SAMPLE_CYC(100),
                          .REFRESH_W(4), .BLANK_LZ(0)) dut_a (
        .clk(clk), .rst(rst), .auto_en(auto_en), .man_sel(man_sel), .value_in(value_a),
        .sel_out(sel_a), .busy(busy_a), .Anode(anode_a), .LED_out(led_a));

    ssd_scan_controller #(.NUM_W(NUM_W), .NUM_SRC(12), .DWELL_CYC(40), .SAMPLE_CYC(100),
                          .REFRESH_W(4), .BLANK_LZ(1)) dut_b (
        .clk(clk), .rst(rst), .auto_en(auto_en), .man_sel(man_sel), .value_in(value_b),
        .sel_out(sel_b), .busy(busy_b), .Anode(anode_b), .LED_out(led_b));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int limit, input string name);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (busy_a == lvl) break;
        end
        check(name, {31'd0, busy_a}, {31'd0, lvl});
    endtask

    task automatic check_display(input string name, input logic [27:0] exp, input bit use_b);
        logic [7:0] got [4];
        logic [3:0] an;
        logic [6:0] led;
        for (int k = 0; k < 4; k++) got[k] = 8'hFF;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            an  = use_b ? anode_b : anode_a;
            led = use_b ? led_b : led_a;
            case (an)
                4'b0111: got[0] = {1'b0, led};
                4'b1011: got[1] = {1'b0, led};
                4'b1101: got[2] = {1'b0, led};
                4'b1110: got[3] = {1'b0, led};
                default: ;
            endcase
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("%s digit%0d", name, k), {24'd0, got[k]}, {25'd0, exp[27-7*k -: 7]});
    endtask

    // While a conversion is in flight, every digit shown must still be the old value.
    task automatic check_hold(input string name, input logic [27:0] exp, input int max_cyc);
        int k;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (!busy_a) break;
            case (anode_a)
                4'b0111: k = 0;
                4'b1011: k = 1;
                4'b1101: k = 2;
                default: k = 3;
            endcase
            check($sformatf("%s digit%0d", name, k), {25'd0, led_a}, {25'd0, exp[27-7*k -: 7]});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [9];
        logic [3:0] prev, exp_sel;
        logic b0;
        int cnt, blen;
        bit first;

        vecs[0] = '{14'd1234,  {S1, S2, S3, S4}, {S1, S2, S3, S4}};
        vecs[1] = '{14'd9999,  {S9, S9, S9, S9}, {S9, S9, S9, S9}};
        vecs[2] = '{14'd10000, {SD, SD, SD, SD}, {SD, SD, SD, SD}};
        vecs[3] = '{14'd7,     {S0, S0, S0, S7}, {SB, SB, SB, S7}};
        vecs[4] = '{14'd0,     {S0, S0, S0, S0}, {SB, SB, SB, S0}};
        vecs[5] = '{14'd908,   {S0, S9, S0, S8}, {SB, S9, S0, S8}};
        vecs[6] = '{14'd40,    {S0, S0, S4, S0}, {SB, SB, S4, S0}};
        vecs[7] = '{14'd16383, {SD, SD, SD, SD}, {SD, SD, SD, SD}};
        vecs[8] = '{14'd1005,  {S1, S0, S0, S5}, {S1, S0, S0, S5}};

        for (int i = 0; i < 16; i++) src_val[i] = 14'(100 + i * 11);
        src_val[0] = 14'd4321;
        src_val[3] = 14'd567;
        src_val[5] = 14'd8080;

        // Reset state
        rst = 1'b0; auto_en = 1'b0; man_sel = 4'd0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy_a}, 32'd0);
        check("reset anode", {28'd0, anode_a}, 32'hF);
        check("reset led", {25'd0, led_a}, 32'h7F);
        check("reset sel", {28'd0, sel_a}, 32'd0);
        check("reset anode_b", {28'd0, anode_b}, 32'hF);
        rst = 1'b1;
        wait_busy(1'b0, 40, "post-reset idle");

        // Manual vectors, alternating sources 1/2 to force a select-change trigger
        for (int i = 0; i < 9; i++) begin
            wait_busy(1'b0, 40, $sformatf("vec%0d idle", i));
            src_val[(i % 2) ? 2 : 1] = vecs[i].value;
            man_sel = (i % 2) ? 4'd2 : 4'd1;
            wait_busy(1'b1, 10, $sformatf("vec%0d start", i));
            if (i == 0) begin
                blen = 1;
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (!busy_a) break;
                    blen++;
                end
                check("busy length", blen, 32'd16);
            end else begin
                wait_busy(1'b0, 40, $sformatf("vec%0d done", i));
            end
            repeat (2) @(negedge clk);
            check_display($sformatf("vec%0d plain", i), vecs[i].exp_a, 1'b0);
            check_display($sformatf("vec%0d blank", i), vecs[i].exp_b, 1'b1);
        end

        // Auto-scan: 40-cycle dwell, wrap 11 -> 0, conversion starts one cycle after each step
        man_sel = 4'd10;
        repeat (3) @(negedge clk);
        check("auto start sel", {28'd0, sel_a}, 32'd10);
        auto_en = 1'b1;
        prev = 4'd10;
        cnt = 0;
        first = 1'b1;
        for (int s = 0; s < 14; s++) begin
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                cnt++;
                if (sel_a != prev) break;
            end
            exp_sel = (prev == 4'd11) ? 4'd0 : prev + 4'd1;
            check($sformatf("auto step%0d sel", s), {28'd0, sel_a}, {28'd0, exp_sel});
            check($sformatf("auto step%0d dwell", s), cnt, 32'd40);
            prev = sel_a;
            b0 = busy_a;
            @(negedge clk);
            cnt = 1;
            if (!b0) check($sformatf("auto step%0d conv", s), {31'd0, busy_a}, 32'd1);
            first = 1'b0;
        end
        auto_en = 1'b0;

        // Out-of-range manual select
        man_sel = 4'd4;
        repeat (2) @(negedge clk);
        check("man sel 4", {28'd0, sel_a}, 32'd4);
        man_sel = 4'd13;
        repeat (2) @(negedge clk);
        check("man sel 13", {28'd0, sel_a}, 32'd0);
        check("man sel 13 b", {28'd0, sel_b}, 32'd0);

        // Select change during CONV: first result held until UPDATE, pending second conversion
        repeat (40) @(negedge clk);
        wait_busy(1'b0, 40, "t4 idle");
        man_sel = 4'd3;
        wait_busy(1'b1, 5, "t4 start");
        check_hold("t4 hold old", {S4, S3, S2, S1}, 3);
        man_sel = 4'd5;
        check_hold("t4 hold old", {S4, S3, S2, S1}, 40);
        wait_busy(1'b1, 4, "t4 pending restart");
        check_hold("t4 first result", {S0, S5, S6, S7}, 40);
        wait_busy(1'b0, 40, "t4 done");
        repeat (2) @(negedge clk);
        check_display("t4 second result", {S8, S0, S8, S0}, 1'b0);

        // Reset mid-conversion
        man_sel = 4'd3;
        wait_busy(1'b1, 10, "t6 start");
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6 busy", {31'd0, busy_a}, 32'd0);
        check("t6 anode", {28'd0, anode_a}, 32'hF);
        check("t6 led", {25'd0, led_a}, 32'h7F);
        check("t6 sel", {28'd0, sel_a}, 32'd0);
        man_sel = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6 restart", {31'd0, busy_a}, 32'd1);
        wait_busy(1'b0, 40, "t6 done");
        repeat (2) @(negedge clk);
        check_display("t6 result", {S4, S3, S2, S1}, 1'b0);
        check_display("t6 result b", {S4, S3, S2, S1}, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
